// File: rtl/spi_xfer_buffer.sv
`default_nettype none
// =============================================================================
// Module   : spi_xfer_buffer
// Desc     : TX/RX word FIFOs and burst launch control in front of an SPI master.
//            The RX path exists only when SPI_XFER_BUF_RX_EN is defined.
// Revision : 1.0  initial release
// =============================================================================

// -----------------------------------------------------------------------------
// Show-ahead circular FIFO used for both directions
// -----------------------------------------------------------------------------
module spi_xfer_buffer_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    output logic [DATA_WIDTH-1:0]    o_rdata,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic                     o_push_drop
);

    localparam int            c_aw         = $clog2(DEPTH);
    localparam logic [c_aw:0] c_full_level = (c_aw+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]       r_wr_ptr;
    logic [c_aw-1:0]       r_rd_ptr;
    logic [c_aw:0]         r_count;
    logic                  w_pop;
    logic                  w_push;

    assign o_empty     = (r_count == '0);
    assign o_full      = (r_count == c_full_level);
    assign w_pop       = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot, so a push is accepted even when full
    assign w_push      = i_push & (~o_full | w_pop);
    assign o_push_drop = i_push & o_full & ~w_pop;
    assign o_rdata     = o_empty ? '0 : r_mem[r_rd_ptr];
    assign o_level     = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// -----------------------------------------------------------------------------
// Top level
// -----------------------------------------------------------------------------
module spi_xfer_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     tx_wr,
    input  logic [DATA_WIDTH-1:0]    tx_wdata,
    output logic                     tx_full,
    output logic [$clog2(DEPTH):0]   tx_level,
    input  logic                     rx_rd,
    output logic [DATA_WIDTH-1:0]    rx_rdata,
    output logic                     rx_empty,
    output logic [$clog2(DEPTH):0]   rx_level,
    input  logic                     err_clr,
    output logic                     tx_ovf,
    output logic                     rx_ovf,
    output logic                     m_start,
    output logic                     m_txe,
    output logic [DATA_WIDTH-1:0]    m_tx_data,
    input  logic                     m_busy,
    input  logic                     m_done,
    input  logic [DATA_WIDTH-1:0]    m_rx_data
);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_wait_busy = 2'd1;
    localparam logic [1:0] c_st_active    = 2'd2;

    logic [1:0] r_state;
    logic       r_m_start;
    logic       r_tx_ovf;
    logic       w_tx_empty;
    logic       w_tx_pop;
    logic       w_tx_push_drop;
    logic       w_launch;

    assign m_txe    = w_tx_empty | ~enable;
    assign m_start  = r_m_start;
    assign tx_ovf   = r_tx_ovf;
    assign w_launch = (r_state == c_st_idle) & enable & ~w_tx_empty & ~m_busy;
    // The launch word leaves the FIFO on the edge closing the m_start cycle;
    // later words leave on each m_done while the burst is kept alive.
    assign w_tx_pop = r_m_start | ((r_state == c_st_active) & m_done & ~m_txe);

    spi_xfer_buffer_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_tx_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (tx_wr),
        .i_pop       (w_tx_pop),
        .i_wdata     (tx_wdata),
        .o_rdata     (m_tx_data),
        .o_empty     (w_tx_empty),
        .o_full      (tx_full),
        .o_level     (tx_level),
        .o_push_drop (w_tx_push_drop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_st_idle;
            r_m_start <= 1'b0;
        end else begin
            r_m_start <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_launch) begin
                        r_m_start <= 1'b1;
                        r_state   <= c_st_wait_busy;
                    end
                end
                c_st_wait_busy: begin
                    if (m_busy) begin
                        r_state <= c_st_active;
                    end
                end
                c_st_active: begin
                    if (!m_busy) begin
                        r_state <= c_st_idle;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // A new overflow in the clearing cycle keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_ovf <= 1'b0;
        end else if (w_tx_push_drop) begin
            r_tx_ovf <= 1'b1;
        end else if (err_clr) begin
            r_tx_ovf <= 1'b0;
        end
    end

`ifdef SPI_XFER_BUF_RX_EN
    logic r_rx_ovf;
    logic w_rx_push_drop;
    logic w_rx_full_unused;

    spi_xfer_buffer_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_rx_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (m_done),
        .i_pop       (rx_rd),
        .i_wdata     (m_rx_data),
        .o_rdata     (rx_rdata),
        .o_empty     (rx_empty),
        .o_full      (w_rx_full_unused),
        .o_level     (rx_level),
        .o_push_drop (w_rx_push_drop)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ovf <= 1'b0;
        end else if (w_rx_push_drop) begin
            r_rx_ovf <= 1'b1;
        end else if (err_clr) begin
            r_rx_ovf <= 1'b0;
        end
    end

    assign rx_ovf = r_rx_ovf;
`else
    // Write-only build: receive side is tied off and its inputs are ignored
    logic w_rx_unused;

    assign w_rx_unused = ^{rx_rd, m_rx_data};
    assign rx_rdata    = '0;
    assign rx_empty    = 1'b1;
    assign rx_level    = '0;
    assign rx_ovf      = 1'b0;
`endif

endmodule

`default_nettype wire
